// File: rtl/square_sum_acc.sv
// Sum-of-squares accumulator: takes N_SAMPLES squares over a valid/ready input,
// saturates at ACC_W bits, and holds the result until the consumer takes it.
module square_sum_acc #(
  parameter int SQ_W      = 6,
  parameter int N_SAMPLES = 8,
  parameter int ACC_W     = 9,
  parameter int CW        = $clog2(N_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SQ_W-1:0]  sq_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             busy,
  output logic [CW-1:0]    count
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(N_SAMPLES - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   add_r;

  // Top bit of the result flags a carry out; the low ACC_W bits are the clamped sum.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [SQ_W-1:0]  b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(b);
    if (s[ACC_W]) begin
      return {1'b1, {ACC_W{1'b1}}};
    end
    return s;
  endfunction

  assign add_r = sat_add(sum_q, sq_in);

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          sum_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          sum_d = add_r[ACC_W-1:0];
          ovf_d = ovf_q | add_r[ACC_W];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign sum_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign sum_out   = sum_q;
  assign overflow  = ovf_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_square_sum_acc.sv
// Bench for square_sum_acc: a 9-bit and an 8-bit instance share one stimulus stream
// and are compared against a clamped-true-sum reference.
module tb_square_sum_acc;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic [5:0] sq_in;

  logic          in_ready, sum_valid, overflow, busy;
  logic [8:0]    sum_out;
  logic [CW-1:0] count;

  logic          in_ready8, sum_valid8, overflow8, busy8;
  logic [7:0]    sum_out8;
  logic [CW-1:0] count8;

  int checks = 0;
  int failures = 0;

  square_sum_acc #(.SQ_W(6), .N_SAMPLES(8), .ACC_W(9)) dut (
    .clk(clk), .rst(rst), .start(start), .sq_in(sq_in), .in_valid(in_valid),
    .in_ready(in_ready), .sum_out(sum_out), .sum_valid(sum_valid),
    .out_ready(out_ready), .overflow(overflow), .busy(busy), .count(count)
  );

  square_sum_acc #(.SQ_W(6), .N_SAMPLES(8), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .sq_in(sq_in), .in_valid(in_valid),
    .in_ready(in_ready8), .sum_out(sum_out8), .sum_valid(sum_valid8),
    .out_ready(out_ready), .overflow(overflow8), .busy(busy8), .count(count8)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [7:0][5:0] d;
    int              gap;
    int              hold;
    int              exp9;
    int              exp8;
    bit              ov9;
    bit              ov8;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference: the true sum clamped to the accumulator range.
  function automatic int clampw(input int acc, input int w);
    return (acc > (1 << w) - 1) ? (1 << w) - 1 : acc;
  endfunction

  task automatic do_burst(input string nm, input logic [7:0][5:0] d, input int gap,
                          input int hold, output int f9, output int f8,
                          output bit fo9, output bit fo8);
    int acc;
    acc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({nm, "_start_busy"}, busy, 1);
    chk({nm, "_start_rdy"}, in_ready, 1);
    chk({nm, "_start_cnt"}, count, 0);
    chk({nm, "_start_sum"}, sum_out, 0);
    chk({nm, "_start_ovf8"}, overflow8, 0);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        sq_in = 6'($urandom);
        step();
        chk({nm, "_gap_cnt"}, count, i);
        chk({nm, "_gap_sum"}, sum_out, clampw(acc, 9));
      end
      in_valid = 1'b1;
      sq_in = d[i];
      step();
      in_valid = 1'b0;
      acc += int'(d[i]);
      chk({nm, "_sum9"}, sum_out, clampw(acc, 9));
      chk({nm, "_sum8"}, sum_out8, clampw(acc, 8));
      chk({nm, "_ovf9"}, overflow, acc > 511);
      chk({nm, "_ovf8"}, overflow8, acc > 255);
      chk({nm, "_cnt"}, count, i + 1);
      chk({nm, "_vld"}, sum_valid, i == 7);
      chk({nm, "_rdy"}, in_ready, i != 7);
    end
    f9 = int'(sum_out);
    f8 = int'(sum_out8);
    fo9 = overflow;
    fo8 = overflow8;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      sq_in = 6'($urandom_range(1, 63));
      step();
      chk({nm, "_hold_vld"}, sum_valid, 1);
      chk({nm, "_hold_sum"}, sum_out, clampw(acc, 9));
      chk({nm, "_hold_cnt"}, count, 8);
      chk({nm, "_hold_rdy"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({nm, "_done_vld"}, sum_valid, 0);
    chk({nm, "_done_busy"}, busy, 0);
    chk({nm, "_done_sum"}, sum_out, clampw(acc, 9));
  endtask

  vec_t vecs[4];
  int   f9, f8;
  bit   fo9, fo8;

  initial begin
    vecs[0] = '{"sq_ramp", {6'd49, 6'd36, 6'd25, 6'd16, 6'd9, 6'd4, 6'd1, 6'd0},
                0, 0, 140, 140, 1'b0, 1'b0};
    vecs[1] = '{"max_gap", {8{6'd49}}, 2, 0, 392, 255, 1'b0, 1'b1};
    vecs[2] = '{"ramp_hold", {6'd49, 6'd36, 6'd25, 6'd16, 6'd9, 6'd4, 6'd1, 6'd0},
                0, 5, 140, 140, 1'b0, 1'b0};
    vecs[3] = '{"ones", {8{6'd1}}, 0, 0, 8, 8, 1'b0, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sq_in = '0;
    step();
    chk("rst_sum", sum_out, 0);
    chk("rst_cnt", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_vld", sum_valid, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    for (int v = 0; v < 4; v++) begin
      do_burst(vecs[v].name, vecs[v].d, vecs[v].gap, vecs[v].hold, f9, f8, fo9, fo8);
      chk({vecs[v].name, "_tbl_sum9"}, f9, vecs[v].exp9);
      chk({vecs[v].name, "_tbl_sum8"}, f8, vecs[v].exp8);
      chk({vecs[v].name, "_tbl_ovf9"}, fo9, vecs[v].ov9);
      chk({vecs[v].name, "_tbl_ovf8"}, fo8, vecs[v].ov8);
      step();
    end

    // Asynchronous reset in the middle of a burst.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      sq_in = 6'(i * i);
      step();
    end
    in_valid = 1'b0;
    chk("mid_sum", sum_out, 5);
    chk("mid_cnt", count, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_sum", sum_out, 0);
    chk("arst_cnt", count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rdy", in_ready, 0);
    chk("arst_vld", sum_valid, 0);
    step();
    rst = 1'b0;
    step();
    do_burst("post_rst", {6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1}, 0, 1,
             f9, f8, fo9, fo8);
    chk("post_rst_sum", f9, 36);

    // start while busy, and in_valid while idle.
    start = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      sq_in = 6'd2;
      step();
      if (i == 0) chk("acc_start_cnt", count, 1);
    end
    in_valid = 1'b0;
    chk("acc_start_sum", sum_out, 16);
    chk("acc_start_vld", sum_valid, 1);
    out_ready = 1'b0;
    step();
    chk("hold_start_vld", sum_valid, 1);
    chk("hold_start_busy", busy, 1);
    out_ready = 1'b1;
    step();
    chk("hold_exit_busy", busy, 0);
    out_ready = 1'b0;
    start = 1'b0;
    step();
    chk("no_restart_busy", busy, 0);
    in_valid = 1'b1;
    sq_in = 6'd49;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    chk("idle_in_sum", sum_out, 16);
    chk("idle_in_cnt", count, 8);
    chk("idle_in_busy", busy, 0);
    chk("idle_in_rdy", in_ready, 0);

    // Random bursts against the clamped-sum reference.
    for (int r = 0; r < 6; r++) begin
      logic [7:0][5:0] rd;
      int tot;
      tot = 0;
      for (int i = 0; i < 8; i++) begin
        rd[i] = 6'($urandom_range(0, 49));
        tot += int'(rd[i]);
      end
      do_burst("rand", rd, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
               f9, f8, fo9, fo8);
      chk("rand_sum9", f9, clampw(tot, 9));
      chk("rand_sum8", f8, clampw(tot, 8));
      chk("rand_ovf8", fo8, tot > 255);
      if (r[0]) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
